key_conditioner: RTL
====================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), which is the number of consecutive stable synchronized samples needed to accept a level change; legal range 2..2^24.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, which is the number of cycles from the initial press pulse to the first auto-repeat pulse; legal minimum 2.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, which is the number of cycles between successive auto-repeat pulses; legal minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, CLOCK_50 domain.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port i_key_n, input, 1 bit: raw pushbutton, active-low, asynchronous to clk.
REQ-007 The block SHALL have port o_level, output, 1 bit: debounced pressed state, 1 = pressed.
REQ-008 The block SHALL have port o_press, output, 1 bit: one-cycle pulse on an accepted press (and on auto-repeat when enabled).
REQ-009 The block SHALL have port o_release, output, 1 bit: one-cycle pulse on an accepted release.

Function
REQ-010 The block SHALL pass i_key_n through a 2-flop synchronizer, then invert it to give an active-high sample s.
REQ-011 The debounce counter SHALL clear on any cycle where s equals o_level.
REQ-012 The debounce counter SHALL increment on any cycle where s differs from o_level.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while s still differs, the block SHALL toggle o_level on the next edge and clear the counter.
REQ-014 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits, and the counter SHALL never wrap.
REQ-015 For a clean raw edge, o_level SHALL change exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples the new raw value.
REQ-016 Any raw glitch lasting fewer than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on any output.
REQ-017 o_press SHALL be high for exactly one cycle, in the same cycle o_level first reads 1.
REQ-018 o_release SHALL be high for exactly one cycle, in the same cycle o_level first reads 0.
REQ-019 o_press and o_release SHALL never be high in the same cycle.
REQ-020 All outputs SHALL be registered, with no combinational path from i_key_n.
REQ-021 The state machine SHALL have states IDLE (o_level=0), HELD (o_level=1, waiting REPEAT_DELAY) and REPEAT (o_level=1, pulsing every REPEAT_PERIOD).
REQ-022 State transitions SHALL be: IDLE->HELD on accepted press; HELD->REPEAT when the delay expires; HELD or REPEAT->IDLE on accepted release.
REQ-023 An accepted release SHALL take priority over a repeat pulse due in the same cycle: no o_press in that cycle, o_release asserted.

Reset
REQ-024 While reset is high, o_level, o_press and o_release SHALL be 0, both counters 0, state IDLE, and both synchronizer flops 1 (released).
REQ-025 If reset asserts mid-debounce or mid-repeat, the block SHALL discard all progress, with no pulse in or after the reset cycle caused by pre-reset history.
REQ-026 If the key is held through reset deassertion, o_press SHALL fire exactly DEBOUNCE_CYCLES+2 cycles after the first non-reset cycle, and never sooner.

Configuration
REQ-027 With macro KEY_CONDITIONER_REPEAT_EN defined, the block SHALL emit the first extra o_press pulse REPEAT_DELAY cycles after the initial o_press.
REQ-028 With KEY_CONDITIONER_REPEAT_EN defined, the block SHALL emit further o_press pulses every REPEAT_PERIOD cycles while o_level=1.
REQ-029 With KEY_CONDITIONER_REPEAT_EN undefined, the block SHALL omit the REPEAT state and the repeat counter, so that HELD holds until release.
REQ-030 With KEY_CONDITIONER_REPEAT_EN undefined, o_press SHALL pulse only on debounced press edges, and REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-031 Scenario clean press: reset 2 cycles, then i_key_n 1->0 sampled at cycle 0 and held -> o_level=1 and o_press pulse at cycle 6, no other o_press when repeat is disabled.
REQ-032 Scenario bounce: i_key_n alternates 0/1 every 2 cycles for 20 cycles, then rests at 1 -> o_level, o_press and o_release stay 0 throughout.
REQ-033 Scenario release: key held 30 cycles, then released at cycle 0 -> o_release pulse at cycle 6, o_level=0 from cycle 6, no o_press.
REQ-034 Scenario auto-repeat (macro defined): key held 25 cycles after the press pulse at cycle P -> o_press at P, P+10, P+13, P+16, P+19, P+22, P+25.
REQ-035 Scenario mid-debounce reset: press at cycle 0, reset high at cycle 4 for 1 cycle, key still held -> no o_press before cycle 11, o_press at cycle 11.
REQ-036 Scenario release/repeat collision (macro defined): release timed so that the debounce-accept cycle coincides with a due repeat -> o_release=1, o_press=0 in that cycle, state IDLE afterwards.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces an active-low pushbutton, and
// produces a debounced level plus one-cycle press/release pulses.
// Optional auto-repeat of o_press while held: define KEY_CONDITIONER_REPEAT_EN.
// Without the macro the REPEAT state and repeat counter are not built.
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int                DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   // Reject out-of-range configurations at elaboration time.
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777216 ||
       REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
      $error("key_conditioner: parameter out of legal range");
   end

`ifdef KEY_CONDITIONER_REPEAT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;

   localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                              REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W       = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] r_rpt_cnt;
   logic [RPT_W-1:0] w_rpt_cnt_next;
`else
   typedef enum logic {ST_IDLE, ST_HELD} state_t;
`endif

   logic             r_sync1;
   logic             r_sync2;
   logic             r_sample;
   logic [DEB_W-1:0] r_deb_cnt;
   state_t           r_state;
   logic             r_level;
   logic             r_press;
   logic             r_release;

   logic             w_differ;
   logic             w_accept;
   state_t           w_state_next;
   logic             w_level_next;
   logic             w_press_next;
   logic             w_release_next;

   // Two-flop synchronizer plus a registered, inverted (active-high) sample.
   // Reset leaves the synchronizer at "released" so no false press follows.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sample <= 1'b0;
      end else begin
         r_sync1  <= i_key_n;
         r_sync2  <= r_sync1;
         r_sample <= ~r_sync2;
      end
   end

   assign w_differ = r_sample ^ r_level;
   assign w_accept = w_differ && (r_deb_cnt == DEB_LAST);

   // Debounce counter: counts consecutive disagreeing samples, clears on
   // agreement or on acceptance, so it never exceeds DEBOUNCE_CYCLES-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_deb_cnt <= '0;
      end else if (!w_differ || w_accept) begin
         r_deb_cnt <= '0;
      end else begin
         r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
`ifdef KEY_CONDITIONER_REPEAT_EN
         r_rpt_cnt <= '0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_level   <= w_level_next;
         r_press   <= w_press_next;
         r_release <= w_release_next;
`ifdef KEY_CONDITIONER_REPEAT_EN
         r_rpt_cnt <= w_rpt_cnt_next;
`endif
      end
   end

   // Next-state and output decode; an accepted release always wins over a
   // repeat pulse falling due in the same cycle.
   always_comb begin
      w_state_next   = r_state;
      w_level_next   = r_level;
      w_press_next   = 1'b0;
      w_release_next = 1'b0;
`ifdef KEY_CONDITIONER_REPEAT_EN
      w_rpt_cnt_next = '0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = ST_HELD;
               w_level_next = 1'b1;
               w_press_next = 1'b1;
            end
         end
         ST_HELD: begin
            if (w_accept) begin
               w_state_next   = ST_IDLE;
               w_level_next   = 1'b0;
               w_release_next = 1'b1;
            end
`ifdef KEY_CONDITIONER_REPEAT_EN
            else if (r_rpt_cnt == DELAY_LAST) begin
               w_state_next = ST_REPEAT;
               w_press_next = 1'b1;
            end else begin
               w_rpt_cnt_next = r_rpt_cnt + RPT_W'(1);
            end
`endif
         end
`ifdef KEY_CONDITIONER_REPEAT_EN
         ST_REPEAT: begin
            if (w_accept) begin
               w_state_next   = ST_IDLE;
               w_level_next   = 1'b0;
               w_release_next = 1'b1;
            end else if (r_rpt_cnt == PERIOD_LAST) begin
               w_press_next = 1'b1;
            end else begin
               w_rpt_cnt_next = r_rpt_cnt + RPT_W'(1);
            end
         end
`endif
         default: begin
            w_state_next = ST_IDLE;
            w_level_next = 1'b0;
         end
      endcase
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule
